// File: rtl/memory_pkg.sv
// Types and constants shared by the memory-game controller and the upstream card shuffler.
package memory_pkg;

    localparam int NUM_CARDS = 16;
    localparam int NUM_PAIRS = 8;
    localparam int IDX_W     = 4;

    typedef struct packed {
        logic [2:0] symbol;
        logic       face_up;
        logic       matched;
    } card_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FIRST  = 3'd1,
        SECOND = 3'd2,
        CMP    = 3'd3,
        SHOW   = 3'd4,
        OVER   = 3'd5
    } game_state_e;

    // A freshly dealt card is face-down and unmatched.
    function automatic card_t fresh_card(input logic [2:0] symbol);
        return '{symbol: symbol, face_up: 1'b0, matched: 1'b0};
    endfunction

endpackage

// File: rtl/match_timer.sv
// Cycle counter with synchronous clear, count enable and terminal-count compare.
module match_timer #(
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [TW-1:0] term,
    output logic          tc
);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + TW'(1);
        end
    end

    assign tc = (cnt == term);

endmodule

// File: rtl/memory_match_ctrl.sv
// Memory-game controller: loads a shuffled board, flips and compares card pairs,
// keeps per-player scores, a per-turn timeout and the game-over condition.
module memory_match_ctrl
    import memory_pkg::*;
#(
    parameter int SHOW_CYCLES = 4,
    parameter int TURN_CYCLES = 32,
    parameter int TW          = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load,
    input  logic [NUM_CARDS-1:0][4:0]   cards_in,
    input  logic                        sel_valid,
    input  logic [IDX_W-1:0]            sel_idx,
    output logic [NUM_CARDS-1:0][4:0]   board,
    output logic                        player,
    output logic [3:0]                  score0,
    output logic [3:0]                  score1,
    output logic [3:0]                  pairs_left,
    output logic                        sel_err,
    output logic                        match_p,
    output logic                        miss_p,
    output logic                        timeout_p,
    output logic                        game_over,
    output logic [2:0]                  state_o
);

    game_state_e               state_q, state_d;
    card_t [NUM_CARDS-1:0]     board_q;
    logic [IDX_W-1:0]          idx_a, idx_b;
    card_t                     sel_card, card_a, card_b;
    logic                      in_turn, sel_ok, accept, reject, timeout;
    logic                      do_match, do_miss, show_done;
    logic                      tmr_clr, tmr_en, tmr_tc;
    logic [TW-1:0]             tmr_term;
    logic                      unused_low_bits;

    assign sel_card = board_q[sel_idx];
    assign card_a   = board_q[idx_a];
    assign card_b   = board_q[idx_b];

    // Low two bits of each incoming card carry no meaning here.
    always_comb begin
        unused_low_bits = 1'b0;
        for (int k = 0; k < NUM_CARDS; k++) begin
            unused_low_bits = unused_low_bits ^ (^cards_in[k][1:0]);
        end
    end

    always_comb begin
        state_d   = state_q;
        in_turn   = (state_q == FIRST) || (state_q == SECOND);
        sel_ok    = !sel_card.face_up && !sel_card.matched &&
                    ((state_q == FIRST) || (sel_idx != idx_a));
        accept    = in_turn && sel_valid && sel_ok;
        reject    = in_turn && sel_valid && !sel_ok;
        timeout   = in_turn && tmr_tc && !accept;
        do_match  = (state_q == CMP) && (card_a.symbol == card_b.symbol);
        do_miss   = (state_q == CMP) && (card_a.symbol != card_b.symbol);
        show_done = (state_q == SHOW) && tmr_tc;

        case (state_q)
            FIRST: begin
                if (accept)       state_d = SECOND;
                else if (timeout) state_d = FIRST;
            end
            SECOND: begin
                if (accept)       state_d = CMP;
                else if (timeout) state_d = FIRST;
            end
            CMP: begin
                if (do_match) state_d = (pairs_left == 4'd1) ? OVER : FIRST;
                else          state_d = SHOW;
            end
            SHOW: begin
                if (show_done) state_d = FIRST;
            end
            default: state_d = state_q;
        endcase

        if (load) state_d = FIRST;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // One counter serves both the mismatch display window and the turn timeout.
    assign tmr_term = (state_q == SHOW) ? TW'(SHOW_CYCLES - 1) : TW'(TURN_CYCLES - 1);
    assign tmr_clr  = load || accept || timeout || (state_d != state_q);
    assign tmr_en   = in_turn || (state_q == SHOW);

    match_timer #(.TW(TW)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (tmr_clr),
        .en   (tmr_en),
        .term (tmr_term),
        .tc   (tmr_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            board_q    <= '0;
            player     <= 1'b0;
            score0     <= 4'd0;
            score1     <= 4'd0;
            pairs_left <= 4'(NUM_PAIRS);
            idx_a      <= '0;
            idx_b      <= '0;
            sel_err    <= 1'b0;
            match_p    <= 1'b0;
            miss_p     <= 1'b0;
            timeout_p  <= 1'b0;
        end else begin
            sel_err   <= 1'b0;
            match_p   <= 1'b0;
            miss_p    <= 1'b0;
            timeout_p <= 1'b0;
            if (load) begin
                for (int k = 0; k < NUM_CARDS; k++) begin
                    board_q[k] <= fresh_card(cards_in[k][4:2]);
                end
                player     <= 1'b0;
                score0     <= 4'd0;
                score1     <= 4'd0;
                pairs_left <= 4'(NUM_PAIRS);
            end else begin
                sel_err <= reject;
                if (accept) begin
                    board_q[sel_idx].face_up <= 1'b1;
                    if (state_q == FIRST) idx_a <= sel_idx;
                    else                  idx_b <= sel_idx;
                end
                // idx_a is only a live face-up card while waiting for the second pick.
                if (timeout) begin
                    player    <= ~player;
                    timeout_p <= 1'b1;
                    if (state_q == SECOND) board_q[idx_a].face_up <= 1'b0;
                end
                if (do_match) begin
                    board_q[idx_a].matched <= 1'b1;
                    board_q[idx_b].matched <= 1'b1;
                    if (player) score1 <= score1 + 4'd1;
                    else        score0 <= score0 + 4'd1;
                    pairs_left <= pairs_left - 4'd1;
                    match_p    <= 1'b1;
                end
                if (do_miss) miss_p <= 1'b1;
                if (show_done) begin
                    board_q[idx_a].face_up <= 1'b0;
                    board_q[idx_b].face_up <= 1'b0;
                    player                 <= ~player;
                end
            end
        end
    end

    assign board     = board_q;
    assign game_over = (state_q == OVER);
    assign state_o   = state_q;

endmodule

// File: tb/tb_memory_match_ctrl.sv
// Self-checking bench for memory_match_ctrl: table-driven turns plus scoreboarded pulse events.
module tb_memory_match_ctrl;

    localparam logic [3:0] EV_ERR   = 4'b0001;
    localparam logic [3:0] EV_MATCH = 4'b0010;
    localparam logic [3:0] EV_MISS  = 4'b0100;
    localparam logic [3:0] EV_TO    = 4'b1000;

    logic              clk = 1'b0;
    logic              rst, load, sel_valid;
    logic [3:0]        sel_idx;
    logic [15:0][4:0]  cards_in, board;
    logic              player, sel_err, match_p, miss_p, timeout_p, game_over;
    logic [3:0]        score0, score1, pairs_left;
    logic [2:0]        state_o;

    int                checks = 0;
    int                errors = 0;
    logic [3:0]        exp_q[$];
    logic [2:0]        sym_tab[16];

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] evt;
        logic       player;
        logic [3:0] pairs;
        logic [3:0] s0;
        logic [3:0] s1;
    } turn_t;
    turn_t turns[12];

    memory_match_ctrl #(.SHOW_CYCLES(4), .TURN_CYCLES(32), .TW(8)) dut (
        .clk(clk), .rst(rst), .load(load), .cards_in(cards_in),
        .sel_valid(sel_valid), .sel_idx(sel_idx), .board(board),
        .player(player), .score0(score0), .score1(score1), .pairs_left(pairs_left),
        .sel_err(sel_err), .match_p(match_p), .miss_p(miss_p), .timeout_p(timeout_p),
        .game_over(game_over), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every pulse must match the oldest outstanding expected event.
    always @(negedge clk) begin
        logic [3:0] ev;
        ev = {timeout_p, miss_p, match_p, sel_err};
        if (ev != 4'b0000) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pulse_unexpected: got %b expected none", ev);
            end else begin
                chk("pulse_event", ev, exp_q.pop_front());
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic select(input logic [3:0] idx);
        sel_idx   = idx;
        sel_valid = 1'b1;
        tick();
        sel_valid = 1'b0;
    endtask

    task automatic load_board(input bit rev);
        logic [79:0] exp_b;
        for (int k = 0; k < 16; k++) begin
            if (rev) cards_in[k] = {3'((15 - k) >> 1), 2'b10};
            else     cards_in[k] = {3'(k >> 1), 2'b11};
            sym_tab[k] = cards_in[k][4:2];
        end
        load = 1'b1;
        tick();
        load = 1'b0;
        exp_b = '0;
        for (int k = 0; k < 16; k++) exp_b[k*5 +: 5] = {sym_tab[k], 2'b00};
        chk("load_board", board, exp_b);
        chk("load_state", state_o, 3'd1);
        chk("load_scores", {score0, score1, pairs_left}, {4'd0, 4'd0, 4'd8});
        chk("load_player", player, 1'b0);
        chk("load_no_pulse", {sel_err, match_p, miss_p, timeout_p}, 4'b0000);
    endtask

    initial begin
        logic [79:0] saved;
        int          cnt;

        turns[0]  = '{4'd0,  4'd1,  EV_MATCH, 1'b0, 4'd7, 4'd1, 4'd0};
        turns[1]  = '{4'd2,  4'd4,  EV_MISS,  1'b1, 4'd7, 4'd1, 4'd0};
        turns[2]  = '{4'd2,  4'd3,  EV_MATCH, 1'b1, 4'd6, 4'd1, 4'd1};
        turns[3]  = '{4'd4,  4'd6,  EV_MISS,  1'b0, 4'd6, 4'd1, 4'd1};
        turns[4]  = '{4'd4,  4'd5,  EV_MATCH, 1'b0, 4'd5, 4'd2, 4'd1};
        turns[5]  = '{4'd6,  4'd7,  EV_MATCH, 1'b0, 4'd4, 4'd3, 4'd1};
        turns[6]  = '{4'd8,  4'd10, EV_MISS,  1'b1, 4'd4, 4'd3, 4'd1};
        turns[7]  = '{4'd8,  4'd9,  EV_MATCH, 1'b1, 4'd3, 4'd3, 4'd2};
        turns[8]  = '{4'd10, 4'd11, EV_MATCH, 1'b1, 4'd2, 4'd3, 4'd3};
        turns[9]  = '{4'd12, 4'd14, EV_MISS,  1'b0, 4'd2, 4'd3, 4'd3};
        turns[10] = '{4'd12, 4'd13, EV_MATCH, 1'b0, 4'd1, 4'd4, 4'd3};
        turns[11] = '{4'd15, 4'd14, EV_MATCH, 1'b0, 4'd0, 4'd5, 4'd3};

        rst = 1'b1; load = 1'b0; sel_valid = 1'b0; sel_idx = 4'd0; cards_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_board", board, 80'd0);
        chk("reset_ctrl", {player, score0, score1, pairs_left, state_o, game_over},
            {1'b0, 4'd0, 4'd0, 4'd8, 3'd0, 1'b0});
        chk("reset_pulses", {sel_err, match_p, miss_p, timeout_p}, 4'b0000);
        rst = 1'b0;
        tick();

        // IDLE ignores selections without an error pulse.
        select(4'd7);
        tick();
        chk("idle_state", state_o, 3'd0);
        chk("idle_board", board, 80'd0);

        load_board(1'b0);

        for (int i = 0; i < 12; i++) begin
            select(turns[i].a);
            chk("first_state", state_o, 3'd2);
            chk("first_faceup", board[turns[i].a][1], 1'b1);
            exp_q.push_back(turns[i].evt);
            select(turns[i].b);
            chk("cmp_state", state_o, 3'd3);
            tick();
            if (turns[i].evt == EV_MATCH) begin
                chk("match_board_a", board[turns[i].a], {sym_tab[turns[i].a], 2'b11});
                chk("match_board_b", board[turns[i].b], {sym_tab[turns[i].b], 2'b11});
                chk("match_state", state_o, (turns[i].pairs == 4'd0) ? 3'd5 : 3'd1);
            end else begin
                cnt = 0;
                for (int g = 0; g < 16 && state_o == 3'd4; g++) begin
                    if (board[turns[i].a][1] && board[turns[i].b][1]) cnt++;
                    tick();
                end
                chk("show_cycles", cnt, 4);
                chk("miss_board_a", board[turns[i].a], {sym_tab[turns[i].a], 2'b00});
                chk("miss_board_b", board[turns[i].b], {sym_tab[turns[i].b], 2'b00});
                chk("miss_state", state_o, 3'd1);
            end
            chk("turn_player", player, turns[i].player);
            chk("turn_counts", {pairs_left, score0, score1},
                {turns[i].pairs, turns[i].s0, turns[i].s1});
        end

        chk("game_over", {game_over, pairs_left}, {1'b1, 4'd0});
        chk("score_total", 4'(score0 + score1), 4'd8);

        // OVER freezes the board and ignores selections silently.
        saved = board;
        select(4'd3);
        tick();
        chk("over_board", board, saved);
        chk("over_state", state_o, 3'd5);
        chk("queue_after_game", exp_q.size(), 0);

        load_board(1'b0);
        chk("restart_over", game_over, 1'b0);

        // Re-selecting the first card is rejected and stays in SECOND.
        select(4'd5);
        exp_q.push_back(EV_ERR);
        select(4'd5);
        chk("err_same_state", state_o, 3'd2);
        chk("err_same_board", board[5], {sym_tab[5], 2'b10});
        exp_q.push_back(EV_MATCH);
        select(4'd4);
        tick();
        chk("err_match_score", score0, 4'd1);
        saved = board;
        exp_q.push_back(EV_ERR);
        select(4'd4);
        chk("err_matched_board", board, saved);
        chk("err_matched_state", state_o, 3'd1);
        tick();
        chk("queue_after_err", exp_q.size(), 0);

        // Turn timeout: 32 idle cycles in SECOND.
        select(4'd3);
        exp_q.push_back(EV_TO);
        for (int i = 0; i < 31; i++) tick();
        chk("timer_pre_expiry", state_o, 3'd2);
        tick();
        chk("timeout_state", state_o, 3'd1);
        chk("timeout_faceup", board[3][1], 1'b0);
        chk("timeout_player", player, 1'b1);

        // Selection accepted on the expiry cycle wins over the timeout.
        for (int i = 0; i < 31; i++) tick();
        select(4'd6);
        chk("expiry_accept_state", state_o, 3'd2);
        chk("expiry_accept_face", board[6][1], 1'b1);
        chk("expiry_player", player, 1'b1);
        tick();
        chk("queue_after_timeout", exp_q.size(), 0);

        // Load in the middle of a turn: fresh board, no pulses.
        load_board(1'b1);

        // Reset asserted during SHOW returns everything to reset values at once.
        select(4'd0);
        exp_q.push_back(EV_MISS);
        select(4'd2);
        tick();
        chk("pre_rst_state", state_o, 3'd4);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_show_board", board, 80'd0);
        chk("rst_show_ctrl", {state_o, player, score0, score1, pairs_left},
            {3'd0, 1'b0, 4'd0, 4'd0, 4'd8});
        tick();
        rst = 1'b0;
        tick();
        chk("rst_show_idle", state_o, 3'd0);
        chk("queue_final", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_match_ctrl.md
Name: memory_match_ctrl

Overview:
- Game-play controller for the 16-card memory game; sits directly downstream of the card shuffler.
- Loads the shuffled board, accepts player card selections and flips cards face-up.
- Compares pairs, holds mismatches visible, then flips them back. Tracks matched pairs, per-player scores, turn ownership, a per-turn timeout and game over.

Parameters:
- SHOW_CYCLES, 4, cycles a mismatched pair stays face-up before flipping back (>=1)
- TURN_CYCLES, 32, cycles allowed per turn before timeout (>=2)
- TW, 8, width of turn/show counter; must hold max(SHOW_CYCLES, TURN_CYCLES)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- load  in  1  one-cycle pulse: capture cards_in and start a new game
- cards_in  in  16x5  shuffled cards, bits[4:2]=symbol, bits[1:0] ignored
- sel_valid  in  1  player selection strobe
- sel_idx  in  4  selected card position 0..15
- board  out  16x5  live board: [4:2]=symbol, [1]=face_up, [0]=matched
- player  out  1  current player (0/1)
- score0  out  4  pairs won by player 0
- score1  out  4  pairs won by player 1
- pairs_left  out  4  unmatched pairs remaining (8..0)
- sel_err  out  1  one-cycle pulse: selection rejected
- match_p  out  1  one-cycle pulse: pair matched
- miss_p  out  1  one-cycle pulse: pair mismatched
- timeout_p  out  1  one-cycle pulse: turn expired
- game_over  out  1  level, high while in OVER
- state_o  out  3  encoded FSM state, for the display/debug

Behaviour:
- Reset: board all 0, player=0, scores=0, pairs_left=8, all pulses 0, game_over=0, counter=0, state IDLE.
- States: IDLE, FIRST, SECOND, CMP, SHOW, OVER.
- load (any state, highest priority after rst):
  - board[k] <= {cards_in[k][4:2],2'b00}; scores=0; player=0; pairs_left=8; counter=0.
  - Next state FIRST. Aborts any turn in progress; no pulses that cycle.
- IDLE: ignores sel_valid; sel_err stays 0.
- FIRST: sel_valid with board[sel_idx] face_up=0 and matched=0:
  - Set face_up; latch idx_a; counter=0; -> SECOND.
  - Card face-up visible on board the cycle after the strobe.
- SECOND: valid selection as above, idx != idx_a:
  - Set face_up; latch idx_b; -> CMP.
- Invalid selection in FIRST/SECOND (face_up, matched, or equal to idx_a):
  - sel_err pulses next cycle; board and state unchanged; counter not reset.
- sel_valid in CMP/SHOW/OVER: ignored silently, no sel_err.
- CMP (exactly one cycle):
  - Symbols equal: both cards matched=1 (face_up stays 1); current player's score +1; pairs_left -1; match_p pulses.
    - Next: OVER if pairs_left reaches 0, else FIRST with the same player.
  - Symbols differ: miss_p pulses; counter=0; -> SHOW.
- SHOW:
  - Counter increments each cycle.
  - When counter==SHOW_CYCLES-1: clear face_up on idx_a/idx_b; toggle player; counter=0; -> FIRST.
- Turn timer: counts in FIRST/SECOND, cleared on entry to FIRST and on every accepted selection.
  - At count==TURN_CYCLES-1 with no accepted selection that cycle: clear face_up on idx_a if set; toggle player; timeout_p pulses; -> FIRST.
  - A selection accepted in the same cycle as expiry wins; no timeout.
- OVER: game_over=1; board frozen; exit only via load or rst.
- Scores saturate at 8 by construction; no wrap logic. pairs_left never underflows.
- Reset asserted mid-turn or mid-SHOW: immediate return to reset values.

Decomposition:
- Shared package memory_pkg holds:
  - NUM_CARDS=16 and NUM_PAIRS=8.
  - card_t packed struct {symbol[2:0], face_up, matched}; shared with the shuffler output format.
  - game_state_e enum with encodings IDLE=0, FIRST=1, SECOND=2, CMP=3, SHOW=4, OVER=5.
- Sub-module match_timer: TW-bit counter with clear/enable/terminal-count compare, used for both SHOW and turn timeout.

Test Plan:
- Load with cards_in[k].symbol=k>>1; select 0 then 1 -> match_p after CMP; board[0]=board[1]=5'b00011; score0=1; pairs_left=7; player stays 0.
- Select 0 then 2 (symbols 0,1) -> miss_p; both face-up for exactly SHOW_CYCLES=4 cycles, then board[0]=5'b00000, board[2]=5'b00100; player=1.
- Select 5 then 5 again -> sel_err pulse, remains SECOND; select already-matched card 0 -> sel_err, board unchanged.
- Select 3, then idle 32 cycles -> timeout_p; board[3] face_up cleared; player toggles; state FIRST.
- Match all 8 pairs alternating players per the above stimulus -> game_over=1, pairs_left=0, score0+score1=8; further sel_valid ignored; load restarts at FIRST with scores 0.
- Assert rst during SHOW, and separately load during SECOND -> rst: board all 0, IDLE; load: new board, face_up bits 0, state FIRST, no pulses.
